ram8_access_ctrl: RTL

Request/response front-end that sits directly upstream of the 8-word, 16-bit register RAM. It accepts single-word read and write requests over a valid/ready handshake and drives the RAM's load, address and data inputs from registers. It samples the RAM's combinational read output into a registered response. An optional sequencer clears all eight words to zero on command.

---
 rtl/ram8_access_ctrl_if.sv | 30 +++
 rtl/ram8_access_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/ram8_access_ctrl_if.sv
// ram8_access_ctrl_if: request/response bundle between a requester and
// the ram8_access_ctrl front-end.
//
// Handshake: a request transfers on a rising clock edge where
// req_valid && req_ready are both 1. The requester holds req_we/req_addr/
// req_wdata stable while req_valid is high and not yet accepted.
// rsp_valid is a one-cycle pulse qualifying rsp_rdata; there is no response
// backpressure, and responses return in request order.
interface ram8_access_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram8_access_ctrl.sv
// ram8_access_ctrl: registered request/response front-end for the 8-word
// register RAM. Drives the RAM load/address/data from registers and
// registers the RAM's combinational read output into a response pulse.
// Optional clear sequencer is enabled by defining RAM8_CTRL_CLEAR_EN.
module ram8_access_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  ram8_access_ctrl_if.slave bus,
  input  logic              clr_start,
  output logic              busy,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_in,
  input  logic [WIDTH-1:0]  ram_out,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        r_state;
  logic              r_load;
  logic [ADDR_W-1:0] r_address;
  logic [WIDTH-1:0]  r_in;
  logic              r_rd_pend;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_rdata;
  logic              w_accept;

`ifdef RAM8_CTRL_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_cnt;

  // Requests are only taken in IDLE; a clear command takes priority.
  assign bus.req_ready = (r_state == ST_IDLE) && !clr_start && !reset;
  assign busy          = (r_state == ST_CLEAR);
`else
  logic w_unused_clr_start;

  // Without the sequencer nothing ever stalls a request.
  assign w_unused_clr_start = clr_start;
  assign bus.req_ready      = !reset;
  assign busy               = 1'b0;
`endif

  assign w_accept = bus.req_valid && bus.req_ready;

  // RAM drive registers, read-pending flag and the optional clear sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_load    <= 1'b0;
      r_address <= '0;
      r_in      <= '0;
      r_rd_pend <= 1'b0;
`ifdef RAM8_CTRL_CLEAR_EN
      r_clr_cnt <= '0;
`endif
    end else begin
      r_load    <= 1'b0;
      r_rd_pend <= w_accept && !bus.req_we;
      if (w_accept) begin
        r_address <= bus.req_addr;
        if (bus.req_we) begin
          r_in   <= bus.req_wdata;
          r_load <= 1'b1;
        end
      end
`ifdef RAM8_CTRL_CLEAR_EN
      if ((r_state == ST_IDLE) && clr_start) begin
        // Address 0 is written in the first CLEAR cycle; the counter
        // already points at the next address.
        r_state   <= ST_CLEAR;
        r_load    <= 1'b1;
        r_address <= '0;
        r_in      <= '0;
        r_clr_cnt <= ADDR_W'(1);
      end else if (r_state == ST_CLEAR) begin
        if (r_address == '1) begin
          r_state <= ST_IDLE;
        end else begin
          r_load    <= 1'b1;
          r_address <= r_clr_cnt;
          r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
      end
`endif
    end
  end

  // Capture RAM read data one cycle after the read address is driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_rsp_rdata <= ram_out;
      end
    end
  end

  assign ram_load      = r_load;
  assign ram_address   = r_address;
  assign ram_in        = r_in;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign dbg_state     = r_state;

endmodule
